// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM with ready handshake and wait timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [9:0]  addr0,
  output logic        ack0,
  output logic [19:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [9:0]  addr1,
  input  logic [19:0] wdata1,
  output logic        ack1,
  output logic [19:0] rdata1,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [19:0] mem_wdata,
  input  logic [19:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 20;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACC  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt, wait_cnt_next;
  logic            grant, grant_next;
  logic            last, last_next;
  logic            pick;
  logic            ack0_next, ack1_next, err_next, mem_req_next, mem_we_next, busy_next;
  logic [AW-1:0]   mem_addr_next;
  logic [DW-1:0]   mem_wdata_next, rdata0_next, rdata1_next;

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    grant_next     = grant;
    last_next      = last;
    ack0_next      = 1'b0;
    ack1_next      = 1'b0;
    err_next       = 1'b0;
    mem_req_next   = 1'b0;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    rdata0_next    = rdata0;
    rdata1_next    = rdata1;
    // On a tie the port not served last wins; a lone requester always wins
    pick           = (req0 && req1) ? ~last : req1;

    unique case (state)
      IDLE: begin
        if (mem_ready && (req0 || req1)) begin
          grant_next   = pick;
          last_next    = pick;
          mem_req_next = 1'b1;
          state_next   = ISSUE;
          if (pick) begin
            mem_we_next    = we1;
            mem_addr_next  = addr1;
            mem_wdata_next = wdata1;
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = addr0;
            mem_wdata_next = '0;
          end
        end
      end
      ISSUE: begin
        wait_cnt_next = '0;
        state_next    = WAIT_ACC;
      end
      WAIT_ACC: begin
        wait_cnt_next = wait_cnt + CW'(1);
        if (wait_cnt_next == CW'(TIMEOUT)) begin
          ack0_next  = ~grant;
          ack1_next  = grant;
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (!mem_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wait_cnt_next = wait_cnt + CW'(1);
        if (mem_ready) begin
          ack0_next  = ~grant;
          ack1_next  = grant;
          state_next = IDLE;
          if (!mem_we) begin
            if (grant) rdata1_next = mem_rdata;
            else       rdata0_next = mem_rdata;
          end
        end else if (wait_cnt_next == CW'(TIMEOUT)) begin
          ack0_next  = ~grant;
          ack1_next  = grant;
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State, latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      grant     <= 1'b0;
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      grant     <= grant_next;
      last      <= last_next;
      ack0      <= ack0_next;
      ack1      <= ack1_next;
      err       <= err_next;
      busy      <= busy_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      rdata0    <= rdata0_next;
      rdata1    <= rdata1_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, vector table, scoreboard and multi-cycle corner cases.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [19:0] wdata1;
  logic        ack0, ack1, err, mem_req, mem_we, mem_ready, busy;
  logic [19:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mreq_cnt = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: latches the request, goes busy for lat cycles, then returns ready
  logic [9:0]  ram [1024];
  logic [19:0] ram_q = '0;
  logic        ready_r = 1'b1;
  int          ram_cnt = 0;
  int          lat = 2;
  logic        stuck = 1'b0;
  logic        hold_busy = 1'b0;

  assign mem_ready = hold_busy ? 1'b0 : ready_r;
  assign mem_rdata = ram_q;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 10'(i * 37 + 1);
    ram[10] = 10'd5;
    ram[11] = 10'd3;
    ram[50] = 10'd9;
  end

  always @(posedge clk) begin
    if (!stuck && mem_req && ready_r) begin
      if (mem_we) ram[mem_addr] <= mem_addr[0] ? mem_wdata[19:10] : mem_wdata[9:0];
      else        ram_q <= {ram[mem_addr | 10'd1], ram[mem_addr & 10'h3FE]};
      ready_r <= 1'b0;
      ram_cnt <= lat;
    end else if (!ready_r) begin
      if (ram_cnt <= 1) ready_r <= 1'b1;
      else              ram_cnt <= ram_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected completions, in ack order
  typedef struct {
    logic        port;
    logic [19:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic p, input logic [19:0] rd, input logic e);
    exp_t x;
    x.port = p; x.rdata = rd; x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: pops the scoreboard on every ack and watches protocol invariants
  logic       prev_mreq = 1'b0;
  logic       prev_busy = 1'b0;
  logic [9:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        mreq_cnt++;
        check("mem_req_one_cycle", 32'(prev_mreq), 32'd0);
      end
      if (busy && prev_busy) check("mem_addr_hold", 32'(mem_addr), 32'(prev_addr));
      if (ack0 || ack1) begin
        check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_port", 32'(ack1), 32'(e.port));
          check("rdata", 32'(ack1 ? rdata1 : rdata0), 32'(e.rdata));
          check("err", 32'(err), 32'(e.err));
        end
      end else if (err) begin
        check("err_without_ack", 32'(err), 32'd0);
      end
    end
    prev_mreq = mem_req;
    prev_busy = busy;
    prev_addr = mem_addr;
  end

  // Raise a request at a negedge, hold it until the port's ack, then drop it
  task automatic drive(input logic p, input logic we, input logic [9:0] a,
                       input logic [19:0] wd, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    if (!p) begin addr0 = a; req0 = 1'b1; end
    else    begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = p ? ack1 : ack0;
    end
    if (!p) req0 = 1'b0;
    else    req1 = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic check_reset();
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [19:0] wdata;
    logic [19:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   n, n2, m0, c1, c2, k;
    logic seen;

    // Writes expect the port's rdata to stay at its previous value
    vecs[0] = '{1'b0, 1'b0, 10'd10,   20'h00000, 20'h00C05};
    vecs[1] = '{1'b1, 1'b1, 10'd51,   20'hFFC00, 20'h00000};
    vecs[2] = '{1'b1, 1'b0, 10'd50,   20'h00000, 20'hFFC09};
    vecs[3] = '{1'b1, 1'b1, 10'd20,   20'h00123, 20'hFFC09};
    vecs[4] = '{1'b0, 1'b0, 10'd20,   20'h00000, 20'hC2923};
    vecs[5] = '{1'b1, 1'b0, 10'd11,   20'h00000, 20'h00C05};
    vecs[6] = '{1'b0, 1'b0, 10'd1023, 20'h00000, 20'hF73B7};
    vecs[7] = '{1'b1, 1'b0, 10'd0,    20'h00000, 20'h09801};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].port, vecs[i].exp_rdata, 1'b0);
      m0 = mreq_cnt;
      drive(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, n);
      check("latency_min", 32'(n >= 4), 32'd1);
      check("mem_req_per_txn", 32'(mreq_cnt - m0), 32'd1);
      @(negedge clk);
    end

    // Simultaneous requests after reset: port 0 first, then strict alternation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      push(1'b0, 20'h00C05, 1'b0);
      push(1'b1, 20'hFFC09, 1'b0);
    end
    fork
      begin repeat (3) drive(1'b0, 1'b0, 10'd10, 20'h0, n); end
      begin repeat (3) drive(1'b1, 1'b0, 10'd50, 20'h0, n2); end
    join
    @(negedge clk);

    // Reset during WAIT_DONE: no ack, outputs cleared at once, fresh request completes
    lat = 6;
    addr0 = 10'd0;
    req0 = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      seen = mem_req;
    end
    check("issue_before_reset", 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("busy_in_wait_done", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 2;
    push(1'b0, 20'h00C05, 1'b0);
    drive(1'b0, 1'b0, 10'd10, 20'h0, n);
    @(negedge clk);

    // RAM never goes busy: timeout with err, rdata0 kept
    stuck = 1'b1;
    push(1'b0, 20'h00C05, 1'b1);
    c1 = 0;
    c2 = 0;
    fork
      drive(1'b0, 1'b0, 10'd20, 20'h0, n);
      begin
        seen = 1'b0;
        k = 0;
        while (!seen && k < 50) begin @(negedge clk); k++; seen = mem_req; end
        c1 = cyc;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 100) begin @(negedge clk); k++; seen = ack0; end
        c2 = cyc;
        check("timeout_cycles", 32'(c2 - c1), 32'(TIMEOUT + 1));
        @(negedge clk);
        check("busy_after_timeout", 32'(busy), 32'd0);
      end
    join
    stuck = 1'b0;
    @(negedge clk);

    // mem_ready low at request time: no issue until it rises
    hold_busy = 1'b1;
    push(1'b1, 20'hFFC09, 1'b0);
    fork
      drive(1'b1, 1'b0, 10'd50, 20'h0, n);
      begin
        repeat (6) begin
          @(negedge clk);
          check("no_issue_while_not_ready", 32'(mem_req), 32'd0);
        end
        hold_busy = 1'b0;
      end
    join
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
